// File: rtl/cswap_pipe_if.sv
// Transaction bus of the constant-time conditional swap pipeline.
// The master side is the ladder controller; the slave side is the swap pipe.
interface cswap_pipe_if #(
    parameter int WID   = 256,
    parameter int NPAIR = 2
);
    logic                   in_vld;
    logic                   in_rdy;
    logic                   bit_in;
    logic                   ladder;
    logic                   clr_st;
    logic [NPAIR*WID-1:0]   a;
    logic [NPAIR*WID-1:0]   b;
    logic                   out_vld;
    logic                   out_rdy;
    logic [NPAIR*WID-1:0]   aswap;
    logic [NPAIR*WID-1:0]   bswap;
    logic                   swap_st;

    modport master (
        output in_vld, bit_in, ladder, clr_st, a, b, out_rdy,
        input  in_rdy, out_vld, aswap, bswap, swap_st
    );

    modport slave (
        input  in_vld, bit_in, ladder, clr_st, a, b, out_rdy,
        output in_rdy, out_vld, aswap, bswap, swap_st
    );
endinterface

// File: rtl/cswap_pipe.sv
// Pipelined constant-time conditional swap of NPAIR operand pairs for the
// Montgomery ladder, with optional tracking of the previous scalar bit.
module cswap_pipe #(
    parameter int WID   = 256,
    parameter int NPAIR = 2,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    cswap_pipe_if.slave  bus
);
    localparam int BW = NPAIR * WID;

    logic            r_swap_st;
    logic            w_rdy;
    logic            w_acc;
    logic            w_prev;
    logic            w_eff;
    logic [LAT-1:0]  w_adv;
    logic [LAT-1:0]  w_vld;
    logic [BW-1:0]   w_a [LAT];
    logic [BW-1:0]   w_b [LAT];

    // XOR difference under an all-ones/all-zeros mask; no select on operand data.
    function automatic logic [BW-1:0] swap_diff(input logic [BW-1:0] fa,
                                                input logic [BW-1:0] fb,
                                                input logic          eff);
        logic [WID-1:0] m;
        logic [BW-1:0]  d;
        m = {WID{1'b0}} - WID'(eff);
        for (int i = 0; i < NPAIR; i++) begin
            d[i*WID +: WID] = (fa[i*WID +: WID] ^ fb[i*WID +: WID]) & m;
        end
        return d;
    endfunction

    assign w_rdy  = rst & w_adv[0];
    assign w_acc  = bus.in_vld & w_rdy;
    assign w_prev = bus.clr_st ? 1'b0 : r_swap_st;
    assign w_eff  = bus.ladder ? (bus.bit_in ^ w_prev) : bus.bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_swap_st <= 1'b0;
        end else if (w_acc) begin
            r_swap_st <= bus.ladder ? bus.bit_in : w_prev;
        end else if (bus.clr_st) begin
            r_swap_st <= 1'b0;
        end
    end

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        logic            r_vld;
        logic [BW-1:0]   r_a;
        logic [BW-1:0]   r_b;
        logic            w_sv;
        logic            w_se;
        logic [BW-1:0]   w_sa;
        logic [BW-1:0]   w_sb;
        logic [BW-1:0]   w_d;

        // A stage moves whenever some stage at or beyond it has room.
        assign w_adv[k] = bus.out_rdy | ~(&w_vld[LAT-1:k]);

        if (k == 0) begin : g_src
            assign w_sv = w_acc;
            assign w_se = w_eff;
            assign w_sa = bus.a;
            assign w_sb = bus.b;
        end else begin : g_src
            assign w_sv = w_vld[k-1];
            assign w_se = g_stg[k-1].g_keep.r_eff;
            assign w_sa = w_a[k-1];
            assign w_sb = w_b[k-1];
        end

        if (k < LAT - 1) begin : g_keep
            logic r_eff;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_eff <= 1'b0;
                end else if (w_adv[k]) begin
                    r_eff <= w_se;
                end
            end
            assign w_d = '0;
        end else begin : g_swap
            assign w_d = swap_diff(w_sa, w_sb, w_se);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vld <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
            end else if (w_adv[k]) begin
                r_vld <= w_sv;
                r_a   <= w_sa ^ w_d;
                r_b   <= w_sb ^ w_d;
            end
        end

        assign w_vld[k] = r_vld;
        assign w_a[k]   = r_a;
        assign w_b[k]   = r_b;
    end

    assign bus.in_rdy  = w_rdy;
    assign bus.out_vld = w_vld[LAT-1];
    assign bus.aswap   = w_a[LAT-1];
    assign bus.bswap   = w_b[LAT-1];
    assign bus.swap_st = r_swap_st;
endmodule

// File: tb/tb_cswap_pipe.sv
// Bench for cswap_pipe: vector table plus hand sequences, scoreboard on outputs.
module tb_cswap_pipe;
    localparam int WID   = 8;
    localparam int NPAIR = 2;
    localparam int LAT   = 2;
    localparam int BW    = WID * NPAIR;

    typedef struct {
        logic          bit_in;
        logic          ladder;
        logic          clr_st;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          exp_eff;
        logic          exp_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cswap_pipe_if #(.WID(WID), .NPAIR(NPAIR)) bus ();
    cswap_pipe #(.WID(WID), .NPAIR(NPAIR), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall_total = 0;
    logic exp_st_cur = 1'b0;
    logic [2*BW-1:0] sb_q[$];
    int pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*BW-1:0] exp_out(input logic [BW-1:0] a,
                                                 input logic [BW-1:0] b,
                                                 input logic eff);
        return eff ? {b, a} : {a, b};
    endfunction

    function automatic vec_t mk(input logic bi, input logic ld, input logic cl,
                                input logic [BW-1:0] a, input logic [BW-1:0] b,
                                input logic ee, input logic es);
        vec_t v;
        v.bit_in = bi; v.ladder = ld; v.clr_st = cl;
        v.a = a; v.b = b; v.exp_eff = ee; v.exp_st = es;
        return v;
    endfunction

    task automatic send(input vec_t v, input string nm);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        bus.in_vld = 1'b1;
        bus.bit_in = v.bit_in;
        bus.ladder = v.ladder;
        bus.clr_st = v.clr_st;
        bus.a      = v.a;
        bus.b      = v.b;
        #1;
        while (!bus.in_rdy && guard < 40) begin
            @(negedge clk); #2;
            guard++;
        end
        stall_total += guard;
        if (!bus.in_rdy) begin
            check({nm, "_accept_timeout"}, 64'(bus.in_rdy), 64'd1);
            bus.in_vld = 1'b0;
            bus.clr_st = 1'b0;
            return;
        end
        sb_q.push_back(exp_out(v.a, v.b, v.exp_eff));
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        bus.clr_st = 1'b0;
        check({nm, "_swap_st"}, 64'(bus.swap_st), 64'(v.exp_st));
        exp_st_cur = v.exp_st;
    endtask

    // Output monitor: pops the scoreboard on every output handshake.
    initial begin
        logic [2*BW-1:0] e;
        forever begin
            @(negedge clk); #2;
            if (rst && bus.out_vld && bus.out_rdy) begin
                e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                check("out_data", 64'({bus.aswap, bus.bswap}), 64'(e));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        vec_t bp[5];
        logic [2*BW-1:0] bp0;
        int n;

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 16'h1122, 16'h3344, 1'b1, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 1'b0, 16'h1122, 16'h3344, 1'b0, 1'b0);
        tbl[2] = mk(1'b1, 1'b1, 1'b1, 16'hA1B2, 16'hC3D4, 1'b1, 1'b1);
        tbl[3] = mk(1'b1, 1'b1, 1'b0, 16'h5A5A, 16'h0F0F, 1'b0, 1'b1);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 16'hFF00, 16'h00FF, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 1'b1, 1'b0, 16'h1234, 16'h8765, 1'b1, 1'b1);
        tbl[6] = mk(1'b0, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);

        bus.in_vld = 1'b0; bus.bit_in = 1'b0; bus.ladder = 1'b0; bus.clr_st = 1'b0;
        bus.a = '0; bus.b = '0; bus.out_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_out_vld", 64'(bus.out_vld), 64'd0);
        check("rst_aswap",   64'(bus.aswap),   64'd0);
        check("rst_bswap",   64'(bus.bswap),   64'd0);
        check("rst_swap_st", 64'(bus.swap_st), 64'd0);
        check("rst_in_rdy",  64'(bus.in_rdy),  64'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);

        // Latency of a lone transaction
        send(tbl[0], "lat");
        for (int c = 1; c < LAT; c++) begin
            check("lat_early", 64'(bus.out_vld), 64'd0);
            @(posedge clk); #1;
        end
        check("lat_exact", 64'(bus.out_vld), 64'd1);
        repeat (LAT + 2) @(negedge clk);

        // Table vectors, back to back
        for (int i = 0; i < 7; i++) send(tbl[i], $sformatf("tbl%0d", i));
        repeat (LAT + 2) @(negedge clk);

        // Streaming: 8 transactions with out_rdy held high
        stall_total = 0;
        for (int i = 0; i < 8; i++) begin
            v = mk(1'($urandom), 1'b0, 1'b0, BW'($urandom), BW'($urandom), 1'b0, exp_st_cur);
            v.exp_eff = v.bit_in;
            send(v, $sformatf("stream%0d", i));
        end
        repeat (LAT + 3) @(negedge clk);
        check("stream_no_stall", 64'(stall_total), 64'd0);
        n = pop_cyc.size();
        check("stream_consecutive", 64'(pop_cyc[n-1] - pop_cyc[n-8]), 64'd7);

        // Backpressure: hold out_rdy low while the pipe fills
        for (int i = 0; i < 5; i++) begin
            bp[i] = mk(1'(i & 1), 1'b0, 1'b0, BW'($urandom), BW'($urandom), 1'(i & 1), exp_st_cur);
        end
        bp0 = exp_out(bp[0].a, bp[0].b, bp[0].exp_eff);
        @(negedge clk); #1;
        bus.out_rdy = 1'b0;
        send(bp[0], "bp0");
        send(bp[1], "bp1");
        @(negedge clk); #2;
        check("bp_in_rdy_low", 64'(bus.in_rdy), 64'd0);
        check("bp_out_vld", 64'(bus.out_vld), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("bp_hold", 64'({bus.aswap, bus.bswap}), 64'(bp0));
            check("bp_in_rdy_hold", 64'(bus.in_rdy), 64'd0);
        end
        fork
            begin
                @(negedge clk); #1;
                bus.out_rdy = 1'b1;
            end
            send(bp[2], "bp2");
        join
        send(bp[3], "bp3");
        send(bp[4], "bp4");
        repeat (LAT + 3) @(negedge clk);
        check("bp_drained", 64'(sb_q.size()), 64'd0);

        // clr_st while idle
        send(mk(1'b1, 1'b1, 1'b1, 16'h0102, 16'h0304, 1'b1, 1'b1), "clr_set");
        @(posedge clk); #1;
        check("idle_keeps_st", 64'(bus.swap_st), 64'd1);
        @(negedge clk); #1;
        bus.clr_st = 1'b1;
        @(posedge clk); #1;
        check("clr_idle", 64'(bus.swap_st), 64'd0);
        bus.clr_st = 1'b0;
        send(mk(1'b1, 1'b1, 1'b0, 16'h5566, 16'h7788, 1'b1, 1'b1), "clr_after");
        repeat (LAT + 2) @(negedge clk);

        // Asynchronous reset in the middle of a stream
        send(mk(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b1), "mid0");
        send(mk(1'b1, 1'b1, 1'b0, 16'hC0DE, 16'hF00D, 1'b0, 1'b1), "mid1");
        check("mid_out_vld", 64'(bus.out_vld), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_vld", 64'(bus.out_vld), 64'd0);
        check("arst_swap_st", 64'(bus.swap_st), 64'd0);
        check("arst_aswap",   64'(bus.aswap),   64'd0);
        check("arst_bswap",   64'(bus.bswap),   64'd0);
        sb_q.delete();
        exp_st_cur = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_release_in_rdy", 64'(bus.in_rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            check("arst_no_stale", 64'(bus.out_vld), 64'd0);
        end

        repeat (LAT + 2) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cswap_pipe.md
Name: cswap_pipe

Overview:
- Parametrised, pipelined, constant-time conditional swap for the Montgomery-ladder scalar multiplier.
- Swaps NPAIR operand pairs in one transaction, for example (X2,X3) and (Z2,Z3) together.
- Uses a branch-free XOR mask in place of a mux, and adds a valid/ready handshake with backpressure.
- Optional ladder mode tracks the previous scalar bit internally, so the caller supplies raw scalar bits instead of precomputed swap flags.

Parameters:
- WID, 256, width in bits of one operand (X25519 field element).
- NPAIR, 2, number of operand pairs swapped by one shared swap decision.
- LAT, 2, pipeline register stages from accept to output; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_vld  in  1  input transaction valid.
- in_rdy  out  1  block can accept an input this cycle.
- bit_in  in  1  swap flag (direct mode) or current scalar bit k_t (ladder mode).
- ladder  in  1  1 = ladder mode, 0 = direct mode; sampled on accept.
- clr_st  in  1  clears stored previous bit; takes effect on accept or when in_vld=0.
- a  in  NPAIR*WID  first operand of each pair; pair i at [i*WID +: WID].
- b  in  NPAIR*WID  second operand of each pair; same packing as a.
- out_vld  out  1  output transaction valid.
- out_rdy  in  1  downstream accepts output this cycle.
- aswap  out  NPAIR*WID  a when effective swap=0, else b (per pair).
- bswap  out  NPAIR*WID  b when effective swap=0, else a (per pair).
- swap_st  out  1  stored previous bit (ladder state), for debug/final fixup.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valids, data registers, eff registers and swap_st go to 0.
  - Hence out_vld=0, aswap=0, bswap=0, swap_st=0.
  - in_rdy=0 only while rst=0; it is 1 in the first cycle after release.
- Accept condition: in_vld & in_rdy. Output handshake: out_vld & out_rdy.
- Effective swap on accept:
  - ladder=0: eff = bit_in.
  - ladder=1: eff = bit_in ^ prev, where prev = (clr_st ? 0 : swap_st).
- swap_st update:
  - On accept with ladder=1: swap_st <= bit_in.
  - On accept with ladder=0: swap_st <= (clr_st ? 0 : swap_st).
  - clr_st with no accept: swap_st <= 0.
- Constant-time swap:
  - mask m = 0 - {WID-1 zeros, eff} (all-ones or all-zeros).
  - d_i = (a_i ^ b_i) & m; aswap_i = a_i ^ d_i; bswap_i = b_i ^ d_i.
  - No data-dependent mux select on operand data paths.
- Pipeline:
  - LAT stages, each holding {vld, eff, a, b}; mask/XOR is computed between stages.
  - The final stage drives aswap/bswap directly from flops.
  - Stage k loads when it is empty or its content moves forward that cycle. Stall is a full-pipeline hold; no bubbles are inserted while out_rdy=1.
  - in_rdy = !stage1_vld | stage1 advancing (combinational from out_rdy through the stage chain).
  - Throughput: 1 transaction/cycle with out_rdy=1. Latency: exactly LAT cycles from accept edge to out_vld high.
- Backpressure (out_rdy=0 with out_vld=1):
  - Outputs hold stable; no data is dropped or duplicated.
  - The pipeline fills up to LAT entries, then in_rdy=0.
- Ordering: strictly in order; one output per accepted input.
- Non-accepted inputs (in_vld=0 or in_rdy=0) never modify swap_st, except via clr_st.
- Ladder fixup: after the final scalar bit, the caller issues one transaction with bit_in=0, ladder=1. This gives eff = swap_st, undoing the last pending swap.
- Reset mid-operation clears in-flight transactions and the ladder state; nothing is emitted after reset for them.

Test Plan:
- Direct swap, WID=8, NPAIR=2, LAT=2: a={8'h11,8'h22}, b={8'h33,8'h44}, bit_in=1, ladder=0 -> after 2 cycles out_vld=1, aswap={8'h33,8'h44}, bswap={8'h11,8'h22}. Same with bit_in=0 -> passthrough.
- Ladder sequence: bits 1,1,0,1 then fixup 0 (ladder=1, clr_st=1 on first) -> eff 1,0,1,1,1; swap_st after each accept 1,1,0,1,0.
- Streaming: 8 back-to-back transactions with out_rdy=1 -> in_rdy stays 1, outputs appear on 8 consecutive cycles in input order.
- Backpressure: out_rdy=0 for 5 cycles during a stream -> in_rdy drops after LAT accepts, aswap/bswap held constant. Release -> no loss or duplication; all results correct.
- clr_st while idle (in_vld=0) with swap_st=1 -> swap_st=0 next cycle. The next ladder accept with bit_in=1 gives eff=1.
- Async reset asserted mid-stream (between clock edges) -> out_vld, swap_st, aswap and bswap go to 0 immediately. After release, in_rdy=1 and no stale outputs appear.
